// File: rtl/weight_fetch_sequencer_if.sv
// Bus bundle for weight_fetch_sequencer: command/status, ROM pins and the MAC weight stream.
// Handshake: a weight moves on a rising edge where w_valid && w_ready; while w_valid is high
// and w_ready low, w_data/w_last/w_valid stay frozen; w_valid never waits on w_ready.
interface weight_fetch_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] w_data;
  logic              w_valid;
  logic              w_ready;
  logic              w_last;

  modport master (
    output start, base_addr, count, rom_data, w_ready,
    input  busy, done, rom_addr, rom_en, w_data, w_valid, w_last
  );

  modport slave (
    input  start, base_addr, count, rom_data, w_ready,
    output busy, done, rom_addr, rom_en, w_data, w_valid, w_last
  );
endinterface

// File: rtl/weight_fetch_sequencer.sv
// Walks a ROM window (base, count), buffers weights in a small FIFO and streams them to the MAC.
// rom_en is registered and decided from next occupancy, so MAC back-pressure never reaches it combinationally.
module weight_fetch_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  weight_fetch_sequencer_if.slave bus,
  output logic [1:0]             dbg_state_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   xfer_q, xfer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rom_en_q, rom_en_d;
  logic [PTR_W:0]    occ_q, occ_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] tag_q;
  logic              push, pop, w_valid;

  assign w_valid = (occ_q != '0);
  assign push    = rom_en_q;
  assign pop     = w_valid && bus.w_ready;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    issued_d = issued_q;
    addr_d   = addr_q;
    rom_en_d = 1'b0;
    xfer_d   = xfer_q + {{ADDR_W{1'b0}}, pop};
    occ_d    = occ_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          count_d  = bus.count;
          issued_d = '0;
          xfer_d   = '0;
          if (bus.count == '0) begin
            state_d = S_FINISH;
          end else begin
            state_d  = S_FETCH;
            rom_en_d = 1'b1;
            addr_d   = bus.base_addr;
            issued_d = (ADDR_W+1)'(1);
          end
        end
      end
      S_FETCH: begin
        // issued_q already counts the fetch in flight this cycle
        if (rom_en_q && issued_q == count_q) begin
          state_d = S_DRAIN;
        end else if (issued_q != count_q && occ_d < FULL_OCC) begin
          rom_en_d = 1'b1;
          issued_d = issued_q + (ADDR_W+1)'(1);
          addr_d   = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (xfer_d == count_q) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      issued_q <= '0;
      xfer_q   <= '0;
      addr_q   <= '0;
      rom_en_q <= 1'b0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tag_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      xfer_q   <= xfer_d;
      addr_q   <= addr_d;
      rom_en_q <= rom_en_d;
      occ_q    <= occ_d;
      if (push) begin
        mem_q[wr_ptr_q] <= bus.rom_data;
        tag_q[wr_ptr_q] <= (issued_q == count_q);
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  assign bus.busy     = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign bus.done     = (state_q == S_FINISH);
  assign bus.rom_addr = addr_q;
  assign bus.rom_en   = rom_en_q;
  assign bus.w_data   = mem_q[rd_ptr_q];
  assign bus.w_valid  = w_valid;
  assign bus.w_last   = w_valid && tag_q[rd_ptr_q];
  assign dbg_state_o  = state_q;
endmodule

// File: doc/weight_fetch_sequencer.md
# weight_fetch_sequencer

Bus-side reader for the combinational weight ROM. On a start command it walks a contiguous ROM window (base address, count), drives the ROM address/enable pins, captures each weight into a small FIFO, and streams the weights to the neuron MAC datapath over a valid/ready interface, marking the last weight of the window. It sits between the weight ROM and the neuron layer controller and decouples the MAC's back-pressure from ROM addressing.

## Interface
- ADDR_W, 8, ROM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, weight width.
- FIFO_DEPTH, 4, capture FIFO entries; power of two, at least 2.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  first ROM address; sampled with start.
- count  in  ADDR_W+1  number of weights, 0..2^ADDR_W; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the window is fully delivered.
- rom_addr  out  ADDR_W  ROM address, registered.
- rom_en  out  1  ROM enable, registered; high only on fetch cycles.
- rom_data  in  DATA_W  ROM read data; valid in the same cycle as rom_en.
- w_data  out  DATA_W  weight to MAC (FIFO head).
- w_valid  out  1  w_data is valid.
- w_ready  in  1  MAC accepts the weight; a transfer occurs when w_valid and w_ready are both high.
- w_last  out  1  high with the final weight of the window.

## Operation
- States: IDLE, FETCH, DRAIN, FINISH.
- IDLE: start=1 latches base_addr and count. If count=0, go to FINISH and never assert rom_en. Otherwise go to FETCH.
- FETCH: each cycle with issue-count < count and FIFO occupancy < FIFO_DEPTH, the block drives rom_en=1 with rom_addr = base+issued. At the clock edge it pushes rom_data and increments the address (wrap modulo 2^ADDR_W).
  - Once all weights are issued, go to DRAIN.
  - No combinational path from w_ready to rom_en.
- DRAIN: wait until all count weights have transferred, then go to FINISH.
- FINISH: done=1 for one cycle, busy=0, then return to IDLE.
- FIFO: push and pop may occur in the same cycle; occupancy is then unchanged. Pop occurs on a transfer.
- w_last is high when the head entry is weight index count-1. It is stored as a FIFO tag bit.
- w_data, w_last and w_valid hold stable while w_valid=1 and w_ready=0.
- rom_en=0: rom_addr holds its last value. rom_data is ignored (the ROM output is high-Z).
- start while busy is ignored; the command is not queued.
- Reset asserted at any point: FIFO is emptied, counters cleared, state returns to IDLE, and the in-flight window is abandoned.
- Reset values: busy=0, done=0, rom_en=0, rom_addr=0, w_valid=0, w_last=0, w_data=0.

## Timing
- Start sampled at edge E0. The first rom_en/rom_addr=base is active in the cycle after E0, and the weight is captured at E1.
- w_valid first rises after E1: latency of 2 cycles from the start edge to the first w_valid.
- With w_ready held at 1, one weight transfers per cycle. Fetches sustain one per cycle because occupancy settles at 1.
- With w_ready=0, the FIFO fills. rom_en drops in the cycle after occupancy reaches FIFO_DEPTH, and resumes the cycle after the first pop.
- done pulses the cycle after the transfer carrying w_last. busy falls in the same cycle as the done pulse.
- count=0: done pulses the cycle after the start edge, with no ROM or w_valid activity.
- A new start is accepted at the earliest in the cycle after the done pulse.

## Test plan
Bench ROM model: mem[i] = i ^ 8'h5A, with the tri-state output modelled.
- Basic window: start, base=0x10, count=4, w_ready=1 -> w_data sequence 4A,4B,48,49, with w_last on 49. w_valid first rises 2 cycles after start. done pulses one cycle after the last transfer.
- Back-pressure: base=0x00, count=8, w_ready=0 for 10 cycles then 1 -> rom_en is high for exactly 4 cycles, then stalls. w_data holds 5A. Eight weights arrive in order with no loss or duplicates.
- Wrap-around: ADDR_W=8, base=0xFE, count=4 -> rom_addr FE,FF,00,01; data A4,A5,5A,5B.
- Zero/max count: count=0 -> done one cycle after start, rom_en never high. count=256 -> 256 transfers, w_last only on the 256th.
- Start while busy and random w_ready: a second start mid-window is ignored. Random 50% w_ready delivers the exact sequence with the handshake-stability assertion holding throughout.
- Reset mid-operation: assert rst_n=0 after 3 transfers of count=8 -> outputs go to reset values immediately. After release, a new start base=0x20, count=2 delivers 7A,7B correctly.
